// File: rtl/exc_ctrl.sv
// exc_ctrl -- memory-stage exception arbiter in front of the CP0 register block.
//
// Each cycle it folds the per-instruction exception flags and any pending,
// enabled interrupt into one 32-bit exception code. That code goes to CP0 in
// the same cycle, together with the faulting PC, the delay-slot flag and the
// bad address. When an exception commits, the block emits a registered
// one-cycle flush pulse and a redirect PC on the following cycle.
//
// Build option:
//   CP0_INT_SYNC_EN  defined   -> int_i passes through a 2-flop synchroniser
//                    undefined -> int_sync_o = int_i (combinational)
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   stall                     MEM stage stalled; nothing commits while high
//   mem_valid                 MEM slot holds a real instruction
//   mem_pc, mem_in_delayslot  PC / delay-slot flag of the MEM instruction
//   mem_data_addr             load/store effective address
//   exc_*                     per-instruction exception flags
//   cp0_status/cause/epc      current CP0 register values
//   int_i                     raw external interrupt lines
//   int_sync_o                interrupt lines to CP0 cause[15:10]
//   excepttype_o              exception code (0 = none), combinational
//   current_inst_addr_o       mem_pc pass-through
//   is_in_delayslot_o         mem_in_delayslot pass-through
//   bad_addr_o                faulting address (0 unless an address error)
//   flush_o, new_pc_o         registered flush pulse and redirect target
//
// FSM states:
//   state | meaning
//   IDLE  | arbitrating; a nonzero code commits and captures the target
//   FLUSH | flush_o=1 for one cycle with new_pc_o valid; arbitration is off
module exc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [31:0] mem_data_addr,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_tr,
  input  logic        exc_adel_ld,
  input  logic        exc_ades,
  input  logic        exc_eret,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic [5:0]  int_i,
  output logic [5:0]  int_sync_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] CODE_ERET  = 32'h0000_000e;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] target_q;
  logic        int_pend;

  // Only the interrupt-mask/pending fields and IE/EXL are used here.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2],
                             cp0_cause[31:16], cp0_cause[7:0]};

`ifdef CP0_INT_SYNC_EN
  logic [5:0] int_meta, int_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_meta <= '0;
      int_sync <= '0;
    end else begin
      int_meta <= int_i;
      int_sync <= int_meta;
    end
  end

  assign int_sync_o = int_sync;
`else
  assign int_sync_o = int_i;
`endif

  // Interrupts are taken only with IE set and EXL clear.
  assign int_pend = (|(cp0_cause[15:8] & cp0_status[15:8])) &
                    cp0_status[0] & ~cp0_status[1];

  assign current_inst_addr_o = mem_pc;
  assign is_in_delayslot_o   = mem_in_delayslot;

  always_comb begin
    excepttype_o = '0;
    bad_addr_o   = '0;
    if (mem_valid && !stall && state == IDLE) begin
      if (int_pend)         excepttype_o = 32'h1;
      else if (exc_adel_if) begin
        excepttype_o = 32'h4;
        bad_addr_o   = mem_pc;
      end
      else if (exc_ri)      excepttype_o = 32'ha;
      else if (exc_ov)      excepttype_o = 32'hc;
      else if (exc_sys)     excepttype_o = 32'h8;
      else if (exc_bp)      excepttype_o = 32'h9;
      else if (exc_tr)      excepttype_o = 32'hd;
      else if (exc_adel_ld) begin
        excepttype_o = 32'h4;
        bad_addr_o   = mem_data_addr;
      end
      else if (exc_ades) begin
        excepttype_o = 32'h5;
        bad_addr_o   = mem_data_addr;
      end
      else if (exc_eret)    excepttype_o = CODE_ERET;
    end
  end

  // State register plus the redirect target captured at commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      target_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && excepttype_o != '0)
        target_q <= (excepttype_o == CODE_ERET) ? cp0_epc : EXC_VECTOR;
    end
  end

  // FLUSH always returns to IDLE, even if the stage is stalled.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (excepttype_o != '0) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flush_o  = (state == FLUSH);
    new_pc_o = target_q;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Memory-stage exception arbiter for the MIPS pipeline, sitting directly upstream of the CP0 register block. It synchronises external interrupt lines and prioritises per-instruction exception flags and pending interrupts into a single 32-bit exception code. It drives the code together with the faulting PC, delay-slot flag and bad address into CP0 in the same cycle. It also issues a registered one-cycle pipeline flush and redirect PC (exception vector or EPC for ERET).

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  MEM stage stalled; no exception commits while high
- mem_valid  in  1  MEM slot holds a real instruction (not a bubble)
- mem_pc  in  32  PC of MEM instruction
- mem_in_delayslot  in  1  MEM instruction is in a branch delay slot
- mem_data_addr  in  32  load/store effective address
- exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_tr, exc_adel_ld, exc_ades, exc_eret  in  1 each  per-instruction exception flags from upstream stages
- cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 register values
- int_i  in  6  raw external interrupt lines
- int_sync_o  out  6  interrupt lines to CP0 cause[15:10]
- excepttype_o  out  32  exception code to CP0 (0 = none)
- current_inst_addr_o  out  32  = mem_pc
- is_in_delayslot_o  out  1  = mem_in_delayslot
- bad_addr_o  out  32  faulting address
- flush_o  out  1  registered flush pulse
- new_pc_o  out  32  registered redirect target, valid while flush_o=1

## Operation
- Interrupt pending: int_pend = |(cp0_cause[15:8] & cp0_status[15:8]) & cp0_status[0] & ~cp0_status[1].
- Arbitration applies only when mem_valid=1, stall=0 and state=IDLE; otherwise excepttype_o=0.
- Priority, highest first:
  - int_pend → 0x1
  - exc_adel_if → 0x4, bad_addr_o=mem_pc
  - exc_ri → 0xa
  - exc_ov → 0xc
  - exc_sys → 0x8
  - exc_bp → 0x9
  - exc_tr → 0xd
  - exc_adel_ld → 0x4, bad_addr_o=mem_data_addr
  - exc_ades → 0x5, bad_addr_o=mem_data_addr
  - exc_eret → 0xe
- bad_addr_o = 0 for every other code.
- FSM states:
  - IDLE: on excepttype_o≠0, capture the target and go to FLUSH. Target is 0xBFC00380 for every code except 0xe, whose target is cp0_epc sampled that cycle.
  - FLUSH: flush_o=1 and new_pc_o=captured target for exactly one cycle, then return to IDLE unconditionally, even if stall=1. Arbitration is suppressed in FLUSH, so the instruction behind the flushed one cannot double-commit.
- Interrupt synchroniser: two flops per line, feeding int_sync_o.

## Timing
- Reset (rst=0, async): state=IDLE, flush_o=0, new_pc_o=0, synchroniser flops=0, int_sync_o=0.
- excepttype_o, bad_addr_o, current_inst_addr_o and is_in_delayslot_o are combinational, so CP0 latches them at the same edge (0 cycles).
- flush_o and new_pc_o rise at the edge following commit: 1-cycle latency, 1-cycle width.
- Stall held high with a pending exception: excepttype_o=0 and no state change. The exception commits in the first cycle stall=0, provided the flags are still present.
- Simultaneous interrupt and ERET: the interrupt wins (0x1), target is 0xBFC00380.
- mem_valid=0 bubble: interrupts are not taken.
- Reset asserted during FLUSH: flush_o drops immediately and asynchronously.

## Configuration
- CP0_INT_SYNC_EN defined: int_i passes through the 2-flop synchroniser; an int_i edge appears on int_sync_o after 2 clk edges.
- CP0_INT_SYNC_EN undefined: int_sync_o = int_i combinationally; no synchroniser flops.

## Test plan
- Reset, then rst=1 idle → all outputs 0; excepttype_o=0 with all flags low.
- mem_valid=1, exc_ov=1, exc_sys=1, mem_pc=0xBFC00100 → excepttype_o=0xc, current_inst_addr_o=0xBFC00100. Next cycle flush_o=1, new_pc_o=0xBFC00380. Following cycle flush_o=0 and the next instruction's exc_sys is ignored only during FLUSH.
- exc_adel_ld=1, mem_data_addr=0x80000003 → excepttype_o=0x4, bad_addr_o=0x80000003. Same test with exc_adel_if=1 also set → bad_addr_o=mem_pc.
- exc_eret=1, cp0_epc=0xBFC00454 → excepttype_o=0xe. Next cycle flush_o=1, new_pc_o=0xBFC00454.
- status=0x00000401, cause=0, int_i=6'b000001 with CP0_INT_SYNC_EN defined → int_sync_o[0]=1 after 2 edges. Once cause reflects it with mem_valid=1 → excepttype_o=0x1. Repeat with status[1]=1 → no exception.
- exc_ri=1 with stall=1 for 3 cycles → excepttype_o=0 and flush_o=0 throughout. At stall=0 → excepttype_o=0xa, flush pulse on the following cycle.
